// File: rtl/picosoc_gpio_pkg.sv
// Shared register map, CTRL/STATUS bit positions and byte-lane merge helper
// for the picosoc GPIO/timer peripheral.
package picosoc_gpio_pkg;

    localparam int unsigned REG_IDX_W = 6;

    localparam logic [REG_IDX_W-1:0] REG_LED    = 6'h00;
    localparam logic [REG_IDX_W-1:0] REG_KEYS   = 6'h01;
    localparam logic [REG_IDX_W-1:0] REG_CNT    = 6'h02;
    localparam logic [REG_IDX_W-1:0] REG_CMP    = 6'h03;
    localparam logic [REG_IDX_W-1:0] REG_CTRL   = 6'h04;
    localparam logic [REG_IDX_W-1:0] REG_STATUS = 6'h05;

    localparam int unsigned CTRL_W       = 3;
    localparam int unsigned CTRL_TEN     = 0;
    localparam int unsigned CTRL_IEN     = 1;
    localparam int unsigned CTRL_ARL     = 2;
    localparam int unsigned STATUS_MATCH = 0;

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

    // Replace the byte lanes of cur selected by wstrb with those of wdata.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single key bit: 2-FF synchronizer, optionally followed by a debounce
// counter when KEY_DEBOUNCE_EN is defined.
module gpio_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic meta;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta   <= din;
            sync_q <= meta;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Output follows the synchronized input only after a full stable run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            dout  <= 1'b0;
        end else if (sync_q == dout) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
            dout  <= sync_q;
        end else begin
            count <= count + CNT_W'(1);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^DEBOUNCE_CYCLES;
    assign dout       = sync_q;
`endif

endmodule

// File: rtl/picosoc_gpio_timer.sv
// picorv32 native-bus peripheral: LED register, synchronized keys and a
// 32-bit compare timer with level irq. Key debounce enabled by KEY_DEBOUNCE_EN.
module picosoc_gpio_timer #(
    parameter int unsigned LED_WIDTH       = 6,
    parameter int unsigned KEY_WIDTH       = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel,
    input  logic                 mem_valid,
    input  logic [7:0]           mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wstrb,
    output logic [31:0]          mem_rdata,
    output logic                 ready,
    output logic [LED_WIDTH-1:0] leds,
    input  logic [KEY_WIDTH-1:0] keys,
    output logic                 irq
);
    import picosoc_gpio_pkg::*;

    logic [31:0]          cnt;
    logic [31:0]          cmp;
    logic [CTRL_W-1:0]    ctrl;
    logic                 match;
    logic [KEY_WIDTH-1:0] keys_db;

    logic                 accept_c;
    logic                 wr_c;
    logic                 rd_c;
    logic                 hit_c;
    logic                 clr_c;
    logic [REG_IDX_W-1:0] idx_c;
    logic [31:0]          rdata_c;

    logic unused_addr;
    assign unused_addr = ^mem_addr[1:0];

    for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_key
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .din  (keys[i]),
            .dout (keys_db[i])
        );
    end

    // Bus decode, timer match detect and read mux.
    always_comb begin
        accept_c = mem_valid && sel && !ready;
        wr_c     = accept_c && (mem_wstrb != 4'b0000);
        rd_c     = accept_c && (mem_wstrb == 4'b0000);
        idx_c    = mem_addr[7:2];
        hit_c    = ctrl[CTRL_TEN] && (cnt == cmp);
        clr_c    = wr_c && (idx_c == REG_STATUS) && mem_wstrb[0]
                   && mem_wdata[STATUS_MATCH];
        rdata_c  = 32'h0;
        case (idx_c)
            REG_LED:    rdata_c = 32'(leds);
            REG_KEYS:   rdata_c = 32'(keys_db);
            REG_CNT:    rdata_c = cnt;
            REG_CMP:    rdata_c = cmp;
            REG_CTRL:   rdata_c = 32'(ctrl);
            REG_STATUS: rdata_c[STATUS_MATCH] = match;
            default:    rdata_c = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready     <= 1'b0;
            mem_rdata <= 32'h0;
        end else begin
            ready     <= accept_c;
            mem_rdata <= rd_c ? rdata_c : 32'h0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds <= '0;
            cmp  <= CMP_RESET;
            ctrl <= '0;
        end else if (wr_c) begin
            if (idx_c == REG_LED)
                leds <= LED_WIDTH'(apply_wstrb(32'(leds), mem_wdata, mem_wstrb));
            if (idx_c == REG_CMP)
                cmp <= apply_wstrb(cmp, mem_wdata, mem_wstrb);
            if (idx_c == REG_CTRL)
                ctrl <= CTRL_W'(apply_wstrb(32'(ctrl), mem_wdata, mem_wstrb));
        end
    end

    // Bus write to CNT overrides reload/increment; a new match beats W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= 32'h0;
            match <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (wr_c && (idx_c == REG_CNT))
                cnt <= apply_wstrb(cnt, mem_wdata, mem_wstrb);
            else if (hit_c && ctrl[CTRL_ARL])
                cnt <= 32'h0;
            else if (ctrl[CTRL_TEN])
                cnt <= cnt + 32'd1;

            if (hit_c)
                match <= 1'b1;
            else if (clr_c)
                match <= 1'b0;

            irq <= match && ctrl[CTRL_IEN];
        end
    end

endmodule

// File: tb/tb_picosoc_gpio_timer.sv
// Directed scoreboard bench for picosoc_gpio_timer; key expectations follow
// KEY_DEBOUNCE_EN when it is defined.
module tb_picosoc_gpio_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        mem_valid;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        ready;
    logic [5:0]  leds;
    logic [4:0]  keys;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    string       q_name[$];
    logic [31:0] q_data[$];

    picosoc_gpio_timer #(
        .LED_WIDTH(6),
        .KEY_WIDTH(5),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .ready    (ready),
        .leds     (leds),
        .keys     (keys),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        else
            n_pass++;
    endfunction

    // Monitor: every ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        string       nm;
        logic [31:0] d;
        if (ready === 1'b1) begin
            if (q_name.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ready: actual=1 required=0");
            end else begin
                nm = q_name.pop_front();
                d  = q_data.pop_front();
                check({nm, "_rdata"}, mem_rdata, d);
            end
        end
    end

    // Called at a negedge; returns at the negedge one cycle after ready.
    task automatic bus(input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp,
                       input string nm);
        mem_valid = 1'b1;
        sel       = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        q_name.push_back(nm);
        q_data.push_back((s == 4'b0000) ? exp : 32'h0);
        @(posedge clk);
        @(negedge clk);
        check({nm, "_ready"}, 32'(ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        check({nm, "_ready_1cyc"}, 32'(ready), 32'h0);
        check({nm, "_rdata_idle"}, mem_rdata, 32'h0);
        mem_valid = 1'b0;
        sel       = 1'b0;
        mem_wstrb = 4'b0000;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input string nm);
        bus(a, d, s, 32'h0, nm);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
        bus(a, 32'h0, 4'b0000, exp, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        sel       = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = 8'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'b0000;
        keys      = 5'b0;
        idle(3);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        idle(1);

        // Register access and byte strobes.
        wr(8'h00, 32'h0000_002A, 4'b0001, "led_wr");
        check("leds_after_wr", 32'(leds), 32'h2A);
        wr(8'h00, 32'h0000_FF3F, 4'b0010, "led_wr_lane1");
        check("leds_lane1_ignored", 32'(leds), 32'h2A);
        rd(8'h00, 32'h0000_002A, "led_rd");
        rd(8'h0C, 32'hFFFF_FFFF, "cmp_rst");
        rd(8'h10, 32'h0, "ctrl_rst");
        rd(8'h14, 32'h0, "status_rst");
        rd(8'h08, 32'h0, "cnt_rst");
        rd(8'h04, 32'h0, "keys_rst");
        wr(8'h40, 32'hDEAD_BEEF, 4'hF, "unmapped_wr");
        rd(8'h40, 32'h0, "unmapped_rd");
        wr(8'h0C, 32'h1234_5678, 4'b0101, "cmp_partial");
        rd(8'h0C, 32'hFF34_FF78, "cmp_partial_rd");

        // Request without region select is ignored.
        mem_valid = 1'b1;
        mem_addr  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check("no_sel_ready", 32'(ready), 32'h0);
        mem_valid = 1'b0;

        // Auto-reload timer: CTRL write accepted at edge E0, matches at E10, E20, ...
        wr(8'h0C, 32'd9, 4'hF, "cmp9");
        wr(8'h08, 32'd0, 4'hF, "cnt0");
        wr(8'h10, 32'h7, 4'hF, "ctrl7");
        idle(8);
        check("irq_before_match", 32'(irq), 32'h0);
        idle(1);
        check("irq_lags_match", 32'(irq), 32'h0);
        idle(1);
        check("irq_set", 32'(irq), 32'h1);
        idle(8);
        wr(8'h14, 32'h1, 4'b0001, "w1c_on_match");
        rd(8'h14, 32'h1, "match_kept");
        wr(8'h14, 32'h1, 4'b0001, "w1c");
        check("irq_cleared", 32'(irq), 32'h0);
        rd(8'h14, 32'h0, "match_cleared");
        idle(3);
        check("irq_before_recur", 32'(irq), 32'h0);
        idle(1);
        check("irq_recur", 32'(irq), 32'h1);
        wr(8'h10, 32'h5, 4'hF, "ien_off");
        check("irq_ien_off", 32'(irq), 32'h0);
        rd(8'h14, 32'h1, "match_ien_off");
        rd(8'h08, 32'd5, "cnt_reload");

        // Free-running wrap with CMP=0, no reload.
        wr(8'h10, 32'h0, 4'hF, "ctrl_stop");
        wr(8'h14, 32'h1, 4'b0001, "w1c_stopped");
        wr(8'h08, 32'hFFFF_FFFE, 4'hF, "cnt_near_wrap");
        wr(8'h0C, 32'h0, 4'hF, "cmp0");
        wr(8'h10, 32'h1, 4'hF, "ctrl_ten");
        rd(8'h08, 32'hFFFF_FFFF, "cnt_wrap_pre");
        rd(8'h14, 32'h1, "match_at_zero");
        rd(8'h08, 32'd3, "cnt_wrap_post");
        check("irq_no_ien", 32'(irq), 32'h0);

        // Keys: synchronizer latency, debounce when enabled.
`ifdef KEY_DEBOUNCE_EN
        keys = 5'b10101;
        idle(5);
        keys = 5'b00000;
        idle(4);
        rd(8'h04, 32'h0, "keys_glitch");
`endif
        keys = 5'b10101;
        rd(8'h04, 32'h0, "keys_sync_lat");
`ifdef KEY_DEBOUNCE_EN
        rd(8'h04, 32'h0, "keys_db_early");
        idle(5);
        rd(8'h04, 32'h0, "keys_db_edge");
        rd(8'h04, 32'h15, "keys_db_stable");
`else
        rd(8'h04, 32'h15, "keys_sync");
`endif

        // Reset during a pending read of CNT.
        wr(8'h10, 32'h3, 4'hF, "ctrl_ten_ien");
        check("irq_pre_reset", 32'(irq), 32'h1);
        mem_valid = 1'b1;
        sel       = 1'b1;
        mem_addr  = 8'h08;
        mem_wstrb = 4'b0000;
        #2 reset = 1'b1;
        #1;
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_rdata", mem_rdata, 32'h0);
        check("reset_leds", 32'(leds), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("reset_no_ready", 32'(ready), 32'h0);
        mem_valid = 1'b0;
        sel       = 1'b0;
        reset     = 1'b0;
        idle(1);
        rd(8'h0C, 32'hFFFF_FFFF, "cmp_after_reset");
        rd(8'h10, 32'h0, "ctrl_after_reset");
        rd(8'h14, 32'h0, "status_after_reset");
        rd(8'h08, 32'h0, "cnt_after_reset");
        check("leds_after_reset", 32'(leds), 32'h0);
        check("irq_after_reset", 32'(irq), 32'h0);

        idle(2);
        while (q_name.size() > 0) begin
            n_checks++;
            $display("FAIL %s: no ready seen, required=1", q_name.pop_front());
            void'(q_data.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
